// File: rtl/tap_mem_pkg.sv
// tap_mem_pkg: shared clear-FSM state type and default tap-memory dimensions
package tap_mem_pkg;
    typedef enum logic {TM_IDLE, TM_CLEAR} tm_state_t;
    localparam int TM_DATA_W = 16;
    localparam int TM_DEPTH = 8;
endpackage

// File: rtl/tap_mem_clear_ctrl.sv
// tap_mem_clear_ctrl: clear-sweep FSM driving one zeroed index per cycle, with busy/clear_done
module tap_mem_clear_ctrl
    import tap_mem_pkg::*;
#(
    parameter int DEPTH = TM_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear_req,
    output logic              busy,
    output logic              clear_done,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_idx
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    tm_state_t state, state_nx;
    logic [ADDR_W-1:0] cnt;
    logic last;
    assign last = cnt == LAST;
    assign busy = state == TM_CLEAR;
    assign clr_en = busy;
    assign clr_idx = cnt;
    always_comb begin
        state_nx = (state == TM_IDLE) ? (clear_req ? TM_CLEAR : TM_IDLE) : (last ? TM_IDLE : TM_CLEAR);
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= TM_IDLE;
            cnt <= '0;
            clear_done <= 1'b0;
        end else begin
            state <= state_nx;
            cnt <= (busy && !last) ? cnt + 1'b1 : '0;
            clear_done <= busy && last;
        end
    end
endmodule

// File: rtl/tap_memory.sv
// tap_memory: DEPTH-entry tap/weight store with shift, write, registered read and clear sweep; TAP_MEM_BYPASS_EN enables write-through reads
module tap_memory
    import tap_mem_pkg::*;
#(
    parameter int DATA_W = TM_DATA_W,
    parameter int DEPTH = TM_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              shift_en,
    input  logic [DATA_W-1:0] shift_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_done,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              clear_req,
    output logic              busy,
    output logic              clear_done,
    output logic              addr_err
);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] mem_nx [DEPTH];
    logic [DATA_W-1:0] rd_word;
    logic clr_en, idle, wr_in, rd_in, wr_ok, rd_ok;
    logic [ADDR_W-1:0] clr_idx;
    tap_mem_clear_ctrl #(.DEPTH(DEPTH)) u_ctrl (
        .clock(clock),
        .reset_n(reset_n),
        .clear_req(clear_req),
        .busy(busy),
        .clear_done(clear_done),
        .clr_en(clr_en),
        .clr_idx(clr_idx)
    );
    assign idle = !clr_en;
    assign wr_in = {1'b0, wr_addr} < DEPTH_L;
    assign rd_in = {1'b0, rd_addr} < DEPTH_L;
    assign wr_ok = idle && wr_en && wr_in;
    assign rd_ok = idle && rd_en;
    always_comb begin
        mem_nx = mem;
        if (clr_en) mem_nx[clr_idx] = '0;
        if (idle && shift_en) begin
            for (int i = DEPTH - 1; i > 0; i--) mem_nx[i] = mem[i-1];
            mem_nx[0] = shift_data;
        end
        if (wr_ok) mem_nx[wr_addr] = wr_data;
    end
`ifdef TAP_MEM_BYPASS_EN
    assign rd_word = rd_in ? mem_nx[rd_addr] : '0;
`else
    assign rd_word = rd_in ? mem[rd_addr] : '0;
`endif
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem <= '{default: '0};
            rd_data <= '0;
            rd_valid <= 1'b0;
            wr_done <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            mem <= mem_nx;
            rd_data <= rd_ok ? rd_word : rd_data;
            rd_valid <= rd_ok;
            wr_done <= wr_ok;
            addr_err <= addr_err || (idle && ((wr_en && !wr_in) || (rd_en && !rd_in)));
        end
    end
endmodule

// File: tb/tb_tap_memory.sv
// tb_tap_memory: randomized and directed checks of tap_memory against an array model
module tb_tap_memory;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic shift_en, wr_en, rd_en, clear_req;
    logic [15:0] shift_data, wr_data;
    logic [2:0] wr_addr, rd_addr;
    logic [15:0] rd_data;
    logic rd_valid, wr_done, busy, clear_done, addr_err;

    logic wr_en6, rd_en6, zero6;
    logic [2:0] wr_addr6, rd_addr6;
    logic [15:0] wr_data6, zdata6, rd_data6;
    logic rd_valid6, wr_done6, busy6, clear_done6, addr_err6;

    tap_memory #(.DATA_W(16), .DEPTH(8)) dut (
        .clock(clock), .reset_n(reset_n), .shift_en(shift_en), .shift_data(shift_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .clear_req(clear_req), .busy(busy), .clear_done(clear_done), .addr_err(addr_err)
    );

    tap_memory #(.DATA_W(16), .DEPTH(6)) dut6 (
        .clock(clock), .reset_n(reset_n), .shift_en(zero6), .shift_data(zdata6),
        .wr_en(wr_en6), .wr_addr(wr_addr6), .wr_data(wr_data6), .wr_done(wr_done6),
        .rd_en(rd_en6), .rd_addr(rd_addr6), .rd_data(rd_data6), .rd_valid(rd_valid6),
        .clear_req(zero6), .busy(busy6), .clear_done(clear_done6), .addr_err(addr_err6)
    );

    int total = 0;
    int bad = 0;
    logic [15:0] model [8];
    logic [15:0] exp_rd_data;
    logic exp_rd_valid, exp_wr_done;

    task automatic idle_in();
        shift_en = 0; wr_en = 0; rd_en = 0; clear_req = 0;
        shift_data = 0; wr_data = 0; wr_addr = 0; rd_addr = 0;
        wr_en6 = 0; rd_en6 = 0; wr_addr6 = 0; rd_addr6 = 0; wr_data6 = 0;
        zero6 = 0; zdata6 = 0;
    endtask

    // One idle-state clock of the DEPTH=8 instance, with the model advanced by the documented rules.
    task automatic step();
        logic [15:0] post [8];
        post = model;
        if (shift_en) begin
            for (int i = 7; i > 0; i--) post[i] = model[i-1];
            post[0] = shift_data;
        end
        if (wr_en) post[wr_addr] = wr_data;
        exp_wr_done = wr_en;
        exp_rd_valid = rd_en;
`ifdef TAP_MEM_BYPASS_EN
        if (rd_en) exp_rd_data = post[rd_addr];
`else
        if (rd_en) exp_rd_data = model[rd_addr];
`endif
        @(posedge clock);
        #1;
        model = post;
        idle_in();
    endtask

    task automatic test_reset();
        idle_in();
        reset_n = 0;
        repeat (2) @(posedge clock);
        #1;
        model = '{default: 16'h0};
        exp_rd_data = 0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0h exp=0", busy); end
        total++; if (rd_valid !== 1'b0 || wr_done !== 1'b0 || clear_done !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%b%b%b exp=000", rd_valid, wr_done, clear_done); end
        total++; if (rd_data !== 16'h0) begin bad++; $display("FAIL reset_rd_data got=%h exp=0000", rd_data); end
        total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL reset_addr_err got=%b exp=0", addr_err); end
        reset_n = 1;
        for (int a = 0; a < 8; a++) begin
            rd_en = 1; rd_addr = 3'(a);
            step();
            total++; if (rd_valid !== 1'b1 || rd_data !== 16'h0) begin bad++; $display("FAIL reset_read[%0d] got v=%b d=%h exp v=1 d=0000", a, rd_valid, rd_data); end
        end
        total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL reset_read_addr_err got=%b exp=0", addr_err); end
    endtask

    task automatic test_shift();
        for (int k = 1; k <= 9; k++) begin
            shift_en = 1; shift_data = 16'(k);
            step();
        end
        for (int a = 0; a < 8; a++) begin
            rd_en = 1; rd_addr = 3'(a);
            step();
            total++; if (rd_valid !== 1'b1 || rd_data !== 16'(9 - a)) begin bad++; $display("FAIL shift_read[%0d] got v=%b d=%h exp v=1 d=%h", a, rd_valid, rd_data, 16'(9 - a)); end
        end
    endtask

    task automatic test_write();
        logic [15:0] old;
        old = model[3];
        wr_en = 1; wr_addr = 3; wr_data = 16'hABCD; rd_en = 1; rd_addr = 3;
        step();
        total++; if (wr_done !== 1'b1) begin bad++; $display("FAIL write_done got=%b exp=1", wr_done); end
`ifdef TAP_MEM_BYPASS_EN
        total++; if (rd_data !== 16'hABCD) begin bad++; $display("FAIL write_same_read got=%h exp=abcd", rd_data); end
`else
        total++; if (rd_data !== old) begin bad++; $display("FAIL write_same_read got=%h exp=%h", rd_data, old); end
`endif
        step();
        total++; if (wr_done !== 1'b0 || rd_valid !== 1'b0) begin bad++; $display("FAIL write_pulse_width got done=%b v=%b exp 0 0", wr_done, rd_valid); end
        rd_en = 1; rd_addr = 3;
        step();
        total++; if (rd_data !== 16'hABCD) begin bad++; $display("FAIL write_later_read got=%h exp=abcd", rd_data); end
    endtask

    task automatic test_shift_write();
        logic [15:0] prev0;
        prev0 = model[0];
        shift_en = 1; shift_data = 16'h0005; wr_en = 1; wr_addr = 0; wr_data = 16'h0077;
        step();
        total++; if (wr_done !== 1'b1) begin bad++; $display("FAIL shiftwr_done got=%b exp=1", wr_done); end
        rd_en = 1; rd_addr = 0;
        step();
        total++; if (rd_data !== 16'h0077) begin bad++; $display("FAIL shiftwr_m0 got=%h exp=0077", rd_data); end
        rd_en = 1; rd_addr = 1;
        step();
        total++; if (rd_data !== prev0) begin bad++; $display("FAIL shiftwr_m1 got=%h exp=%h", rd_data, prev0); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            shift_en = 1'($urandom_range(0, 1));
            shift_data = 16'($urandom);
            wr_en = 1'($urandom_range(0, 1));
            wr_addr = 3'($urandom_range(0, 7));
            wr_data = 16'($urandom);
            rd_en = 1'($urandom_range(0, 1));
            rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom_range(0, 7));
            step();
            total++; if (rd_valid !== exp_rd_valid || rd_data !== exp_rd_data || wr_done !== exp_wr_done) begin
                bad++; $display("FAIL random[%0d] got v=%b d=%h wd=%b exp v=%b d=%h wd=%b", n, rd_valid, rd_data, wr_done, exp_rd_valid, exp_rd_data, exp_wr_done);
            end
        end
    endtask

    task automatic test_clear();
        logic [15:0] held;
        for (int a = 0; a < 8; a++) begin
            wr_en = 1; wr_addr = 3'(a); wr_data = 16'($urandom_range(1, 65535));
            step();
        end
        held = rd_data;
        clear_req = 1;
        @(posedge clock); #1;
        for (int c = 0; c < 8; c++) begin
            total++; if (busy !== 1'b1 || clear_done !== 1'b0) begin bad++; $display("FAIL clear_cycle[%0d] got busy=%b done=%b exp 1 0", c, busy, clear_done); end
            if (c > 0) begin
                total++; if (wr_done !== 1'b0 || rd_valid !== 1'b0) begin bad++; $display("FAIL clear_ignore[%0d] got wd=%b v=%b exp 0 0", c, wr_done, rd_valid); end
            end
            clear_req = (c < 7);
            wr_en = 1; wr_addr = 0; wr_data = 16'h5A5A;
            rd_en = 1; rd_addr = 3'(c);
            shift_en = (c == 7); shift_data = 16'h1111;
            @(posedge clock); #1;
            idle_in();
        end
        total++; if (busy !== 1'b0 || clear_done !== 1'b1) begin bad++; $display("FAIL clear_end got busy=%b done=%b exp 0 1", busy, clear_done); end
        total++; if (wr_done !== 1'b0 || rd_valid !== 1'b0 || rd_data !== held) begin bad++; $display("FAIL clear_last_ignore got wd=%b v=%b d=%h exp 0 0 %h", wr_done, rd_valid, rd_data, held); end
        model = '{default: 16'h0};
        step();
        total++; if (clear_done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL clear_done_width got done=%b busy=%b exp 0 0", clear_done, busy); end
        for (int a = 0; a < 8; a++) begin
            rd_en = 1; rd_addr = 3'(a);
            step();
            total++; if (rd_valid !== 1'b1 || rd_data !== 16'h0) begin bad++; $display("FAIL clear_read[%0d] got v=%b d=%h exp 1 0000", a, rd_valid, rd_data); end
        end
        for (int a = 0; a < 8; a++) begin
            shift_en = 1; shift_data = 16'(a + 100);
            step();
        end
        clear_req = 1;
        @(posedge clock); #1;
        clear_req = 0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 0;
        #1;
        total++; if (busy !== 1'b0 || clear_done !== 1'b0) begin bad++; $display("FAIL clear_abort got busy=%b done=%b exp 0 0", busy, clear_done); end
        @(posedge clock); #1;
        reset_n = 1;
        model = '{default: 16'h0};
        exp_rd_data = 0;
        rd_en = 1; rd_addr = 7;
        step();
        total++; if (rd_valid !== 1'b1 || rd_data !== 16'h0 || busy !== 1'b0) begin bad++; $display("FAIL abort_read got v=%b d=%h busy=%b exp 1 0000 0", rd_valid, rd_data, busy); end
    endtask

    task automatic test_range();
        total++; if (addr_err6 !== 1'b0) begin bad++; $display("FAIL range_init got=%b exp=0", addr_err6); end
        wr_en6 = 1; wr_addr6 = 7; wr_data6 = 16'hBEEF;
        @(posedge clock); #1; idle_in();
        total++; if (wr_done6 !== 1'b0 || addr_err6 !== 1'b1) begin bad++; $display("FAIL range_write got wd=%b err=%b exp 0 1", wr_done6, addr_err6); end
        wr_en6 = 1; wr_addr6 = 5; wr_data6 = 16'h1234;
        @(posedge clock); #1; idle_in();
        total++; if (wr_done6 !== 1'b1) begin bad++; $display("FAIL range_inwrite got=%b exp=1", wr_done6); end
        rd_en6 = 1; rd_addr6 = 5;
        @(posedge clock); #1; idle_in();
        total++; if (rd_valid6 !== 1'b1 || rd_data6 !== 16'h1234) begin bad++; $display("FAIL range_inread got v=%b d=%h exp 1 1234", rd_valid6, rd_data6); end
        rd_en6 = 1; rd_addr6 = 6;
        @(posedge clock); #1; idle_in();
        total++; if (rd_valid6 !== 1'b1 || rd_data6 !== 16'h0) begin bad++; $display("FAIL range_read got v=%b d=%h exp 1 0000", rd_valid6, rd_data6); end
        repeat (5) @(posedge clock);
        #1;
        total++; if (addr_err6 !== 1'b1) begin bad++; $display("FAIL range_sticky got=%b exp=1", addr_err6); end
        total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL range_d8_clean got=%b exp=0", addr_err); end
        reset_n = 0;
        #1;
        total++; if (addr_err6 !== 1'b0) begin bad++; $display("FAIL range_reset got=%b exp=0", addr_err6); end
        @(posedge clock); #1;
        reset_n = 1;
    endtask

    initial begin
        test_reset();
        test_shift();
        test_write();
        test_shift_write();
        test_random();
        test_clear();
        test_range();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
